hwpe_stream_serialize_sched: RTL and testbench

//  Job-level scheduler for an NB_IN_STREAMS-way stream serializer. Drives its ctrl_serdes_t
//  (nb_contig_m1, clear_serdes_state, first_stream) and gates its output handshake.

---
 rtl/hwpe_stream_serialize_sched.sv | 171 +++++++++++++++++
 tb/tb_hwpe_stream_serialize_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_serialize_sched.sv
// Job-level scheduler for an NB_IN_STREAMS-way stream serializer: drives ctrl_serdes_t and gates the pop handshake.
// Optional stall counter on port stall_cnt_o when HWPE_STREAM_SERIALIZE_SCHED_PERF_EN is defined.

package hwpe_stream_serialize_sched_pkg;
  typedef struct packed {
    logic        clear_serdes_state;
    logic [7:0]  first_stream;
    logic [31:0] nb_contig_m1;
  } ctrl_serdes_t;
endpackage

module hwpe_stream_serialize_sched
  import hwpe_stream_serialize_sched_pkg::*;
#(
  parameter int unsigned NB_IN_STREAMS = 2,
  parameter int unsigned CONTIG_LIMIT  = 1024,
  parameter int unsigned ROUND_W       = 16,
  localparam int unsigned CONTIG_W     = $clog2(CONTIG_LIMIT),
  localparam int unsigned STREAM_W     = $clog2(NB_IN_STREAMS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [CONTIG_W-1:0] cfg_nb_contig_m1_i,
  input  logic [ROUND_W-1:0]  cfg_nb_rounds_m1_i,
  input  logic [STREAM_W-1:0] cfg_first_stream_i,
  output ctrl_serdes_t        ctrl_o,
  output logic                ser_clear_o,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [STREAM_W-1:0] cur_stream_o
`ifdef HWPE_STREAM_SERIALIZE_SCHED_PERF_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  localparam int unsigned GROUP_W = ROUND_W + STREAM_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CONTIG_W-1:0] r_contig_m1, w_contig_m1_nxt;
  logic [ROUND_W-1:0]  r_rounds_m1, w_rounds_m1_nxt;
  logic [STREAM_W-1:0] r_first, w_first_nxt;
  logic [CONTIG_W-1:0] r_contig_cnt, w_contig_cnt_nxt;
  logic [GROUP_W-1:0]  r_group_cnt, w_group_cnt_nxt;
  logic [STREAM_W-1:0] r_cur, w_cur_nxt;

  logic               w_clr, w_run, w_beat, w_group_end, w_last;
  logic [GROUP_W-1:0] w_groups;

  assign w_clr       = rst_i | clear_i;
  assign w_run       = (r_state == RUN);
  assign w_beat      = in_valid_i & out_ready_i & w_run;
  assign w_groups    = (GROUP_W'(r_rounds_m1) + GROUP_W'(1)) * GROUP_W'(NB_IN_STREAMS);
  assign w_group_end = w_beat & (r_contig_cnt == r_contig_m1);
  assign w_last      = w_group_end & (r_group_cnt == w_groups - GROUP_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_contig_m1  <= '0;
      r_rounds_m1  <= '0;
      r_first      <= '0;
      r_contig_cnt <= '0;
      r_group_cnt  <= '0;
      r_cur        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_contig_m1  <= w_contig_m1_nxt;
      r_rounds_m1  <= w_rounds_m1_nxt;
      r_first      <= w_first_nxt;
      r_contig_cnt <= w_contig_cnt_nxt;
      r_group_cnt  <= w_group_cnt_nxt;
      r_cur        <= w_cur_nxt;
    end
  end

  // The stream pointer is left at first_stream after a job, so the next job resumes there.
  always_comb begin
    w_state_nxt      = r_state;
    w_contig_m1_nxt  = r_contig_m1;
    w_rounds_m1_nxt  = r_rounds_m1;
    w_first_nxt      = r_first;
    w_contig_cnt_nxt = r_contig_cnt;
    w_group_cnt_nxt  = r_group_cnt;
    w_cur_nxt        = r_cur;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt      = RUN;
          w_contig_m1_nxt  = cfg_nb_contig_m1_i;
          w_rounds_m1_nxt  = cfg_nb_rounds_m1_i;
          w_first_nxt      = cfg_first_stream_i;
          w_contig_cnt_nxt = '0;
          w_group_cnt_nxt  = '0;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt      = DONE;
          w_contig_cnt_nxt = '0;
          w_group_cnt_nxt  = '0;
          w_cur_nxt        = r_first;
        end else if (w_group_end) begin
          w_contig_cnt_nxt = '0;
          w_group_cnt_nxt  = r_group_cnt + GROUP_W'(1);
          w_cur_nxt        = (r_cur == STREAM_W'(NB_IN_STREAMS - 1)) ? '0 : r_cur + STREAM_W'(1);
        end else if (w_beat) begin
          w_contig_cnt_nxt = r_contig_cnt + CONTIG_W'(1);
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_clr) begin
      w_state_nxt      = IDLE;
      w_contig_m1_nxt  = '0;
      w_rounds_m1_nxt  = '0;
      w_first_nxt      = '0;
      w_contig_cnt_nxt = '0;
      w_group_cnt_nxt  = '0;
      w_cur_nxt        = '0;
    end
  end

  // Every output except ser_clear_o is forced low while a reset or clear is applied.
  always_comb begin
    ctrl_o                    = '0;
    ser_clear_o               = w_clr;
    out_valid_o               = 1'b0;
    in_ready_o                = 1'b0;
    busy_o                    = 1'b0;
    done_o                    = 1'b0;
    cur_stream_o              = '0;
    if (!w_clr) begin
      ctrl_o.nb_contig_m1       = 32'(r_contig_m1);
      ctrl_o.first_stream       = 8'(r_first);
      ctrl_o.clear_serdes_state = w_last;
      out_valid_o               = in_valid_i & w_run;
      in_ready_o                = out_ready_i & w_run;
      busy_o                    = (r_state != IDLE);
      done_o                    = (r_state == DONE);
      cur_stream_o              = r_cur;
    end
  end

`ifdef HWPE_STREAM_SERIALIZE_SCHED_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_stall_cnt <= '0;
    end else if (r_state == IDLE && start_i) begin
      r_stall_cnt <= '0;
    end else if (w_run && in_valid_i && !out_ready_i && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = w_clr ? '0 : r_stall_cnt;
`else
`endif

endmodule

// File: tb/tb_hwpe_stream_serialize_sched.sv
// Self-checking bench for hwpe_stream_serialize_sched: one NB=2 and one NB=4 instance,
// each job checked against an arithmetic model of beat count and stream order.

module tb_hwpe_stream_serialize_sched;
  import hwpe_stream_serialize_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clear, start, inValid, outReady;
  logic [9:0]  cfgContig;
  logic [15:0] cfgRounds;
  logic [1:0]  cfgFirst;
  bit          sel;

  ctrl_serdes_t ctrl2, ctrl4;
  logic serClear2, inReady2, outValid2, busy2, done2;
  logic serClear4, inReady4, outValid4, busy4, done4;
  logic [0:0] curStream2;
  logic [1:0] curStream4;
`ifdef HWPE_STREAM_SERIALIZE_SCHED_PERF_EN
  logic [31:0] stall2, stall4;
`endif

  logic start2, start4;
  assign start2 = start & !sel;
  assign start4 = start & sel;

  ctrl_serdes_t obsCtrl;
  logic obsSerClear, obsInReady, obsOutValid, obsBusy, obsDone;
  logic [1:0]  obsCur;
  logic [31:0] obsStall;

  int checks = 0;
  int errors = 0;
  int startStream[2];

  always #5 clk = ~clk;

  hwpe_stream_serialize_sched #(.NB_IN_STREAMS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start2),
    .cfg_nb_contig_m1_i(cfgContig), .cfg_nb_rounds_m1_i(cfgRounds),
    .cfg_first_stream_i(cfgFirst[0]), .ctrl_o(ctrl2), .ser_clear_o(serClear2),
    .in_valid_i(inValid), .in_ready_o(inReady2), .out_valid_o(outValid2),
    .out_ready_i(outReady), .busy_o(busy2), .done_o(done2), .cur_stream_o(curStream2)
`ifdef HWPE_STREAM_SERIALIZE_SCHED_PERF_EN
    , .stall_cnt_o(stall2)
`endif
  );

  hwpe_stream_serialize_sched #(.NB_IN_STREAMS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start4),
    .cfg_nb_contig_m1_i(cfgContig), .cfg_nb_rounds_m1_i(cfgRounds),
    .cfg_first_stream_i(cfgFirst), .ctrl_o(ctrl4), .ser_clear_o(serClear4),
    .in_valid_i(inValid), .in_ready_o(inReady4), .out_valid_o(outValid4),
    .out_ready_i(outReady), .busy_o(busy4), .done_o(done4), .cur_stream_o(curStream4)
`ifdef HWPE_STREAM_SERIALIZE_SCHED_PERF_EN
    , .stall_cnt_o(stall4)
`endif
  );

  // Route the instance under test onto one set of observation signals.
  always_comb begin
    obsStall = '0;
    if (!sel) begin
      obsCtrl = ctrl2; obsSerClear = serClear2; obsInReady = inReady2;
      obsOutValid = outValid2; obsBusy = busy2; obsDone = done2; obsCur = {1'b0, curStream2};
`ifdef HWPE_STREAM_SERIALIZE_SCHED_PERF_EN
      obsStall = stall2;
`endif
    end else begin
      obsCtrl = ctrl4; obsSerClear = serClear4; obsInReady = inReady4;
      obsOutValid = outValid4; obsBusy = busy4; obsDone = done4; obsCur = curStream4;
`ifdef HWPE_STREAM_SERIALIZE_SCHED_PERF_EN
      obsStall = stall4;
`endif
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic r);
    inValid  = v;
    outReady = r;
  endtask

  // Beat k of a job carries stream (s0 + k/(c+1)) mod n; the job has (c+1)*(r+1)*n beats.
  task automatic runJob(input int s, input int c, input int r, input int fs,
                        input bit randMode, input int clrAt, input bit pokes);
    int n, total, beats, cyc, stalls, expStream;
    bit aborted;
    logic v, rd;
    n      = s ? 4 : 2;
    total  = (c + 1) * (r + 1) * n;
    beats  = 0;
    cyc    = 0;
    stalls = 0;
    aborted = 0;
    sel       = s[0];
    cfgContig = 10'(c);
    cfgRounds = 16'(r);
    cfgFirst  = 2'(fs);
    start     = 1'b1;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle_busy", 32'(obsBusy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    while (beats < total && cyc < 2000) begin
      v  = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
      rd = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (clrAt >= 0 && beats == clrAt) begin
        v = 1'b1; rd = 1'b1; clear = 1'b1;
      end
      if (pokes && beats == 2) start = 1'b1;
      applyStimulus(v, rd);
      @(negedge clk);
      if (clear) begin
        checkOutput("clr_ser_clear", 32'(obsSerClear), 1);
        checkOutput("clr_out_valid", 32'(obsOutValid), 0);
        checkOutput("clr_in_ready", 32'(obsInReady), 0);
        checkOutput("clr_busy", 32'(obsBusy), 0);
        @(posedge clk); #1;
        clear = 1'b0;
        aborted = 1;
        break;
      end
      checkOutput("run_busy", 32'(obsBusy), 1);
      checkOutput("run_out_valid", 32'(obsOutValid), 32'(v));
      checkOutput("run_in_ready", 32'(obsInReady), 32'(rd));
      if (v && !rd) stalls++;
      if (v && rd) begin
        expStream = (startStream[s] + beats / (c + 1)) % n;
        checkOutput("beat_stream", 32'(obsCur), 32'(expStream));
        checkOutput("beat_clear_state", 32'(obsCtrl.clear_serdes_state), 32'(beats == total - 1));
        checkOutput("beat_contig_m1", obsCtrl.nb_contig_m1, 32'(c));
        checkOutput("beat_first", 32'(obsCtrl.first_stream), 32'(fs));
        beats++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (aborted) begin
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      checkOutput("abort_busy", 32'(obsBusy), 0);
      checkOutput("abort_done", 32'(obsDone), 0);
      checkOutput("abort_stream", 32'(obsCur), 0);
      startStream[0] = 0;
      startStream[1] = 0;
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0);
      return;
    end
    checkOutput("beat_count", 32'(beats), 32'(total));
    if (!randMode) checkOutput("job_cycles", 32'(cyc), 32'(total));
    applyStimulus(1'b1, 1'b1);
    if (pokes) start = 1'b1;
    @(negedge clk);
    checkOutput("done_pulse", 32'(obsDone), 1);
    checkOutput("done_busy", 32'(obsBusy), 1);
    checkOutput("done_in_ready", 32'(obsInReady), 0);
    checkOutput("done_out_valid", 32'(obsOutValid), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("after_done", 32'(obsDone), 0);
    checkOutput("after_busy", 32'(obsBusy), 0);
    checkOutput("after_out_valid", 32'(obsOutValid), 0);
    checkOutput("after_stream", 32'(obsCur), 32'(fs));
    checkOutput("after_contig_m1", obsCtrl.nb_contig_m1, 32'(c));
`ifdef HWPE_STREAM_SERIALIZE_SCHED_PERF_EN
    checkOutput("stall_cnt", obsStall, 32'(stalls));
`endif
    startStream[s] = fs;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; sel = 1'b0;
    cfgContig = '0; cfgRounds = '0; cfgFirst = '0;
    startStream[0] = 0;
    startStream[1] = 0;
    applyStimulus(1'b1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #0;
      checkOutput("rst_ser_clear", 32'(obsSerClear), 1);
      checkOutput("rst_out_valid", 32'(obsOutValid), 0);
      checkOutput("rst_busy", 32'(obsBusy), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_stream", 32'(obsCur), 0);
    checkOutput("post_rst_ser_clear", 32'(obsSerClear), 0);
    @(posedge clk); #1;

    $display("[TB] NB=2 basic job");
    runJob(0, 3, 0, 0, 1'b0, -1, 1'b0);
    $display("[TB] NB=2 first_stream=1, then resume at stream 1");
    runJob(0, 3, 0, 1, 1'b0, -1, 1'b0);
    runJob(0, 3, 0, 0, 1'b0, -1, 1'b0);
    $display("[TB] NB=4 contig_m1=0 rounds_m1=2");
    runJob(1, 0, 2, 2, 1'b0, -1, 1'b0);
    runJob(1, 1, 0, 3, 1'b0, -1, 1'b0);
    $display("[TB] random handshake");
    runJob(0, 2, 1, 1, 1'b1, -1, 1'b0);
    runJob(1, 2, 1, 0, 1'b1, -1, 1'b0);
    $display("[TB] clear mid-job");
    runJob(0, 3, 0, 1, 1'b0, 4, 1'b0);
    runJob(0, 1, 0, 1, 1'b0, -1, 1'b0);
    $display("[TB] start pulses during RUN and DONE");
    runJob(0, 1, 1, 0, 1'b0, -1, 1'b1);
    runJob(1, 1, 0, 1, 1'b1, -1, 1'b1);
    for (int j = 0; j < 4; j++) begin
      runJob(j % 2, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, (j % 2) ? 3 : 1)), 1'b1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
